// File: rtl/food_spawn_ctrl.sv
// Food placement controller: draws random cells, confirms them with an external
// snake-body checker, and falls back to a raster scan when random draws keep failing.
module food_spawn_ctrl #(
    parameter int CELL_SHIFT = 4,
    parameter int X_CELLS    = 40,
    parameter int Y_CELLS    = 30,
    parameter int MAX_TRIES  = 15
) (
    input  logic       VGA_clk,
    input  logic       reset,
    input  logic [9:0] randX,
    input  logic [8:0] randY,
    input  logic       spawn_req,
    output logic [9:0] occ_query_x,
    output logic [8:0] occ_query_y,
    output logic       occ_query_valid,
    input  logic       occ_resp_valid,
    input  logic       occ_hit,
    output logic [9:0] foodX,
    output logic [8:0] foodY,
    output logic       food_valid,
    output logic       busy,
    output logic       spawn_fail
);
    localparam int TRY_W = $clog2(MAX_TRIES + 1);
    localparam logic [9:0]       X_LIMIT = 10'(X_CELLS);
    localparam logic [8:0]       Y_LIMIT = 9'(Y_CELLS);
    localparam logic [9:0]       X_LAST  = 10'(X_CELLS - 1);
    localparam logic [8:0]       Y_LAST  = 9'(Y_CELLS - 1);
    localparam logic [TRY_W-1:0] TRY_MAX = TRY_W'(MAX_TRIES);

    typedef enum logic [2:0] {
        IDLE, SAMPLE, CHECK, QUERY, WAIT, SCAN_Q, SCAN_W, COMMIT
    } state_t;

    state_t           state_reg, state_next;
    logic [9:0]       cx_reg, cx_next;
    logic [8:0]       cy_reg, cy_next;
    logic [TRY_W-1:0] tries_reg, tries_next;
    logic [9:0]       food_x_reg, food_x_next;
    logic [8:0]       food_y_reg, food_y_next;
    logic             food_valid_reg, food_valid_next;
    logic             busy_reg, busy_next;
    logic             fail_reg, fail_next;
    logic [9:0]       qx_reg, qx_next;
    logic [8:0]       qy_reg, qy_next;
    logic             qvalid_reg, qvalid_next;
    logic             retry;
    logic [TRY_W-1:0] try_inc;

    // Saturating increment so the counter can never wrap back below MAX_TRIES.
    assign try_inc = (tries_reg >= TRY_MAX) ? tries_reg : tries_reg + 1'b1;

    always_ff @(posedge VGA_clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            cx_reg         <= '0;
            cy_reg         <= '0;
            tries_reg      <= '0;
            food_x_reg     <= '0;
            food_y_reg     <= '0;
            food_valid_reg <= 1'b0;
            busy_reg       <= 1'b0;
            fail_reg       <= 1'b0;
            qx_reg         <= '0;
            qy_reg         <= '0;
            qvalid_reg     <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cx_reg         <= cx_next;
            cy_reg         <= cy_next;
            tries_reg      <= tries_next;
            food_x_reg     <= food_x_next;
            food_y_reg     <= food_y_next;
            food_valid_reg <= food_valid_next;
            busy_reg       <= busy_next;
            fail_reg       <= fail_next;
            qx_reg         <= qx_next;
            qy_reg         <= qy_next;
            qvalid_reg     <= qvalid_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cx_next         = cx_reg;
        cy_next         = cy_reg;
        tries_next      = tries_reg;
        food_x_next     = food_x_reg;
        food_y_next     = food_y_reg;
        food_valid_next = food_valid_reg;
        busy_next       = busy_reg;
        fail_next       = fail_reg;
        retry           = 1'b0;

        case (state_reg)
            IDLE: begin
                if (spawn_req) begin
                    food_valid_next = 1'b0;
                    fail_next       = 1'b0;
                    tries_next      = '0;
                    busy_next       = 1'b1;
                    state_next      = SAMPLE;
                end
            end
            SAMPLE: begin
                cx_next    = randX >> CELL_SHIFT;
                cy_next    = randY >> CELL_SHIFT;
                state_next = CHECK;
            end
            CHECK: begin
                if (cx_reg >= X_LIMIT || cy_reg >= Y_LIMIT) begin
                    retry = 1'b1;
                end else begin
                    state_next = QUERY;
                end
            end
            QUERY: state_next = WAIT;
            WAIT: begin
                if (occ_resp_valid) begin
                    if (occ_hit) begin
                        retry = 1'b1;
                    end else begin
                        state_next = COMMIT;
                    end
                end
            end
            SCAN_Q: state_next = SCAN_W;
            SCAN_W: begin
                if (occ_resp_valid) begin
                    if (!occ_hit) begin
                        state_next = COMMIT;
                    end else if (cx_reg == X_LAST && cy_reg == Y_LAST) begin
                        fail_next  = 1'b1;
                        busy_next  = 1'b0;
                        state_next = IDLE;
                    end else if (cx_reg == X_LAST) begin
                        cx_next    = '0;
                        cy_next    = cy_reg + 9'd1;
                        state_next = SCAN_Q;
                    end else begin
                        cx_next    = cx_reg + 10'd1;
                        state_next = SCAN_Q;
                    end
                end
            end
            COMMIT: begin
                food_x_next     = cx_reg << CELL_SHIFT;
                food_y_next     = cy_reg << CELL_SHIFT;
                food_valid_next = 1'b1;
                busy_next       = 1'b0;
                state_next      = IDLE;
            end
            default: state_next = IDLE;
        endcase

        // Shared rejection path for out-of-range samples and occupied cells.
        if (retry) begin
            tries_next = try_inc;
            if (try_inc >= TRY_MAX) begin
                cx_next    = '0;
                cy_next    = '0;
                state_next = SCAN_Q;
            end else begin
                state_next = SAMPLE;
            end
        end
    end

    // Query outputs are registered so they line up with the QUERY/SCAN_Q cycle.
    always_comb begin
        qvalid_next = (state_next == QUERY) || (state_next == SCAN_Q);
        qx_next     = cx_next << CELL_SHIFT;
        qy_next     = cy_next << CELL_SHIFT;
    end

    assign occ_query_x     = qx_reg;
    assign occ_query_y     = qy_reg;
    assign occ_query_valid = qvalid_reg;
    assign foodX           = food_x_reg;
    assign foodY           = food_y_reg;
    assign food_valid      = food_valid_reg;
    assign busy            = busy_reg;
    assign spawn_fail      = fail_reg;

endmodule

// File: doc/food_spawn_ctrl.md
FOOD_SPAWN_CTRL -- requirements
Module: food_spawn_ctrl

Interface
REQ-001 SHALL have parameter CELL_SHIFT, default 4: log2 of the grid cell size in pixels (16 px cells).
REQ-002 SHALL have parameter X_CELLS, default 40: number of playfield columns.
REQ-003 SHALL have parameter Y_CELLS, default 30: number of playfield rows.
REQ-004 SHALL have parameter MAX_TRIES, default 15: random attempts before fallback scan.
REQ-005 SHALL have port VGA_clk, input, 1 bit: the single clock; all logic runs on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port randX, input, 10 bits: pseudo-random X from the LFSR generator, new value every cycle.
REQ-008 SHALL have port randY, input, 9 bits: pseudo-random Y from the LFSR generator, new value every cycle.
REQ-009 SHALL have port spawn_req, input, 1 bit: request a new food position (game start or snake ate food).
REQ-010 SHALL have port occ_query_x, output, 10 bits: pixel X of the candidate cell sent to the body-collision checker.
REQ-011 SHALL have port occ_query_y, output, 9 bits: pixel Y of the candidate cell.
REQ-012 SHALL have port occ_query_valid, output, 1 bit: one-cycle strobe qualifying occ_query_x/y.
REQ-013 SHALL have port occ_resp_valid, input, 1 bit: checker response strobe, arriving any number of cycles (>=1) after the query.
REQ-014 SHALL have port occ_hit, input, 1 bit: valid with occ_resp_valid; 1 = cell occupied by the snake.
REQ-015 SHALL have port foodX, output, 10 bits: committed food pixel X, cell aligned.
REQ-016 SHALL have port foodY, output, 9 bits: committed food pixel Y, cell aligned.
REQ-017 SHALL have port food_valid, output, 1 bit: foodX/foodY hold a committed position.
REQ-018 SHALL have port busy, output, 1 bit: a spawn is in progress.
REQ-019 SHALL have port spawn_fail, output, 1 bit: sticky flag, set when the grid has no free cell.

Function
REQ-020 SHALL implement states IDLE, SAMPLE, CHECK, QUERY, WAIT, SCAN_Q, SCAN_W and COMMIT.
REQ-021 In IDLE, spawn_req=1 SHALL clear food_valid and spawn_fail, clear the try counter, set busy and move to SAMPLE; busy=1 follows in the next cycle.
REQ-022 spawn_req while busy=1 SHALL be ignored: no queueing and no restart.
REQ-023 SAMPLE SHALL register cx=randX>>CELL_SHIFT and cy=randY>>CELL_SHIFT, then move to CHECK.
REQ-024 CHECK SHALL reject the sample if cx>=X_CELLS or cy>=Y_CELLS.
REQ-025 A rejected sample SHALL increment the try counter and return to SAMPLE, or go to SCAN_Q if the counter reaches MAX_TRIES.
REQ-026 CHECK with an in-range sample SHALL move to QUERY.
REQ-027 QUERY SHALL drive occ_query_x=cx<<CELL_SHIFT and occ_query_y=cy<<CELL_SHIFT, assert occ_query_valid for exactly one cycle, then move to WAIT.
REQ-028 In WAIT, occ_resp_valid with occ_hit=0 SHALL move to COMMIT.
REQ-029 In WAIT, occ_resp_valid with occ_hit=1 SHALL count one try and follow the REQ-025 retry/fallback rule.
REQ-030 occ_resp_valid in any state other than WAIT or SCAN_W SHALL be ignored.
REQ-031 On entry to SCAN_Q, cx and cy SHALL reset to 0.
REQ-032 Each SCAN_Q visit SHALL query the current cell as in REQ-027 and move to SCAN_W.
REQ-033 In SCAN_W, hit=0 SHALL move to COMMIT.
REQ-034 In SCAN_W, hit=1 SHALL advance in raster order (cx+1, wrapping to 0 with cy+1 at X_CELLS) and return to SCAN_Q.
REQ-035 In SCAN_W, a hit on cell (X_CELLS-1, Y_CELLS-1) SHALL set spawn_fail, clear busy, leave food_valid=0 and return to IDLE.
REQ-036 COMMIT SHALL load foodX=cx<<CELL_SHIFT and foodY=cy<<CELL_SHIFT, set food_valid, clear busy and return to IDLE, in one cycle.
REQ-037 foodX, foodY and food_valid SHALL hold until the next accepted spawn_req.
REQ-038 Try counter SHALL be width clog2(MAX_TRIES+1) and SHALL saturate, never wrap.
REQ-039 Latency from spawn_req to food_valid, for a first sample in range and free with a 1-cycle checker, SHALL be 6 cycles: IDLE, SAMPLE, CHECK, QUERY, WAIT, COMMIT.

Reset
REQ-040 reset=1 SHALL force IDLE and set foodX=0, foodY=0, food_valid=0, busy=0, spawn_fail=0, occ_query_valid=0, occ_query_x/y=0 and the try counter to 0, with priority over all other inputs.
REQ-041 reset mid-spawn SHALL abandon the spawn; any checker response arriving after reset SHALL be ignored.

Verification
REQ-042 randX=100, randY=200, spawn_req pulse, hit=0 -> occ_query 96/192, then foodX=96, foodY=192, food_valid=1, 6 cycles after spawn_req.
REQ-043 randX=700 for one sample, then 100 -> first sample rejected with no query issued; one query at X=96; commit.
REQ-044 Checker returns hit=1 for 15 queries -> enters SCAN; (0,0) and (1,0) hit, (2,0) free -> foodX=32, foodY=0.
REQ-045 Checker always returns hit=1 -> scan covers 1200 cells, spawn_fail=1, food_valid=0, busy=0.
REQ-046 reset asserted in WAIT, then a late occ_resp_valid -> state IDLE, no commit, all outputs 0.
REQ-047 spawn_req pulsed again while busy -> ignored; exactly one commit occurs.
